serial_subtractor_n: RTL
========================

// Module: serial_subtractor_N
// PURPOSE
//   Multi-cycle unsigned/two's-complement subtractor: diff = a - b - bin, borrow out.
//   Complements the ripple-carry adder family; trades latency for area by processing
//   one W-bit slice per clock through a single W-bit ripple-borrow slice.
//   Valid/ready on both sides; sits between operand producer and result consumer.
// PARAMETERS
//   N  8  operand/result width in bits
//   W  2  slice width per cycle; N % W == 0 required (elaboration error otherwise)
// PORTS
//   clk        in   1  single clock, rising edge
//   rst_n      in   1  asynchronous, active-low reset
//   in_valid   in   1  operands a, b, bin valid
//   in_ready   out  1  block can accept operands (high only in IDLE)
//   a          in   N  minuend
//   b          in   N  subtrahend
//   bin        in   1  borrow in
//   out_valid  out  1  diff/bout valid (high only in DONE)
//   out_ready  in   1  consumer accepts result
//   diff       out  N  a - b - bin, modulo 2^N
//   bout       out  1  borrow out: 1 iff a < b + bin (unsigned)
//   ovf        out  1  signed overflow; present only with SUB_OVF_FLAG_EN
// BEHAVIOUR
//   - Reset (async, rst_n=0): state IDLE, in_ready=1, out_valid=0, diff=0, bout=0,
//     ovf=0, slice index=0, internal borrow=0. Reset mid-BUSY/DONE aborts; result lost.
//   - FSM IDLE -> BUSY on in_valid&&in_ready (accept edge k): capture a, b, bin.
//   - BUSY: on edge k+i (i=1..STEPS, STEPS=N/W) slice i-1 (bits [iW-1:(i-1)W])
//     computed from captured operands and running borrow; written into diff.
//   - Edge k+STEPS: BUSY -> DONE; bout = final borrow; out_valid=1 after this edge.
//   - Latency accept->out_valid: STEPS cycles. Throughput: one op per STEPS+2 cycles min.
//   - DONE: diff/bout/ovf held stable while out_ready=0 (unbounded backpressure).
//   - DONE -> IDLE on out_valid&&out_ready; no accept in same cycle (in_ready=0 in DONE).
//   - in_valid ignored outside IDLE; operand changes after accept have no effect.
//   - diff/bout retain last result in IDLE until next op overwrites (not cleared).
//   - Arithmetic: bit i: d = a^b^bw; bw' = (~a&b)|(~(a^b)&bw). Wrap modulo 2^N.
//   - Boundary: a=b, bin=1 -> diff=all ones, bout=1; a=0,b=0,bin=0 -> 0, bout=0.
// CONFIGURATION
//   SUB_OVF_FLAG_EN defined: port ovf present; ovf = borrow into MSB XOR bout,
//     registered with bout at edge k+STEPS, held in DONE, reset 0.
//   Not defined: ovf port and logic absent; all other behaviour identical.
// STRUCTURE
//   Package sub_pkg: state enum {IDLE, BUSY, DONE}; function for STEPS = N/W;
//     slice-index width helper (clog2 of STEPS, min 1).
//   Sub-module borrow_ripple_slice #(W): combinational W-bit ripple-borrow slice
//     (a_s, b_s, bw_in -> d_s, bw_out, bw_msb_in for overflow); single instance.
//   Top: FSM, slice counter, operand/result shift or indexed registers.
// TESTING  (N=8, W=2, STEPS=4)
//   a=0x35,b=0x12,bin=0 -> diff=0x23,bout=0, out_valid exactly 4 cycles after accept
//   a=0x00,b=0x01,bin=0 -> diff=0xFF,bout=1 (ovf=0 if SUB_OVF_FLAG_EN)
//   a=0x80,b=0x01,bin=0 -> diff=0x7F,bout=0, ovf=1 with SUB_OVF_FLAG_EN
//   a=0x55,b=0x55,bin=1 -> diff=0xFF,bout=1; then out_ready=0 10 cycles -> outputs stable
//   rst_n=0 at 2nd BUSY cycle -> out_valid=0,in_ready=1,diff=0 immediately; next op correct
//   in_valid held high through BUSY/DONE -> exactly one accept per op; back-to-back random
//     ops vs. reference model (a-b-bin mod 256), 1000 vectors, no mismatch

Source files
------------

// File: rtl/serial_subtractor_n_pkg.sv
// Shared types and elaboration helpers for the serial subtractor.
// Package name sub_pkg is kept for drop-in compatibility with existing importers.
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of W-bit slices needed to cover an N-bit operand.
    function automatic int unsigned steps_f(input int unsigned n, input int unsigned w);
        return n / w;
    endfunction

    // Slice-index register width; never narrower than one bit.
    function automatic int unsigned idx_width_f(input int unsigned steps);
        return (steps <= 1) ? 1 : $clog2(steps);
    endfunction

endpackage

// File: rtl/serial_subtractor_n_slice.sv
// Combinational W-bit ripple-borrow slice: d = a - b - bw_in over W bits.
// bw_msb_in exposes the borrow entering the slice MSB for signed-overflow detection.
module borrow_ripple_slice #(
    parameter int unsigned W = 2
) (
    input  logic [W-1:0] a_s,
    input  logic [W-1:0] b_s,
    input  logic         bw_in,
    output logic [W-1:0] d_s,
    output logic         bw_out,
    output logic         bw_msb_in
);

    always_comb begin : ripple
        logic bw;
        bw        = bw_in;
        d_s       = '0;
        bw_msb_in = 1'b0;
        for (int unsigned i = 0; i < W; i++) begin
            if (i == W - 1) begin
                bw_msb_in = bw;
            end
            d_s[i] = a_s[i] ^ b_s[i] ^ bw;
            bw     = (~a_s[i] & b_s[i]) | (~(a_s[i] ^ b_s[i]) & bw);
        end
        bw_out = bw;
    end

endmodule

// File: rtl/serial_subtractor_n.sv
// Multi-cycle subtractor: diff = a - b - bin, one W-bit slice per clock, valid/ready both sides.
// Optional signed-overflow output enabled by defining SUB_OVF_FLAG_EN.
module serial_subtractor_n
    import sub_pkg::*;
#(
    parameter int unsigned N = 8,
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] diff,
    output logic         bout
`ifdef SUB_OVF_FLAG_EN
    ,
    output logic         ovf
`endif
);

    localparam int unsigned STEPS = steps_f(N, W);
    localparam int unsigned IDXW  = idx_width_f(STEPS);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(STEPS - 1);

    if (W == 0 || N % W != 0) begin : g_bad_width
        $error("serial_subtractor_n: N must be a non-zero multiple of W");
    end

    state_t          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            bw_q, bw_d;
    logic [N-1:0]    a_q, a_d;
    logic [N-1:0]    b_q, b_d;
    logic [N-1:0]    diff_q, diff_d;
    logic            bout_q, bout_d;
    logic            ovf_q, ovf_d;

    logic [W-1:0]    a_s, b_s, d_s;
    logic            bw_out, bw_msb_in;

    always_comb begin
        a_s = a_q[idx_q * W +: W];
        b_s = b_q[idx_q * W +: W];
    end

    borrow_ripple_slice #(
        .W (W)
    ) u_slice (
        .a_s       (a_s),
        .b_s       (b_s),
        .bw_in     (bw_q),
        .d_s       (d_s),
        .bw_out    (bw_out),
        .bw_msb_in (bw_msb_in)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        bw_d    = bw_q;
        a_d     = a_q;
        b_d     = b_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    bw_d    = bin;
                    idx_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                diff_d[idx_q * W +: W] = d_s;
                bw_d                   = bw_out;
                if (idx_q == LAST_IDX) begin
                    // Overflow uses the borrow into bit N-1, which is internal to the last slice.
                    bout_d  = bw_out;
                    ovf_d   = bw_msb_in ^ bw_out;
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            bw_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            bw_q    <= bw_d;
            a_q     <= a_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign bout      = bout_q;

`ifdef SUB_OVF_FLAG_EN
    assign ovf = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_q ^ bw_msb_in;
`endif

endmodule
